ysyx_24100005_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single NPC data memory port (the `npcmem_read`/`npcmem_write` DPI path). It sits between the instruction fetch unit (IFU) and the load/store unit (LSU) on one side and the memory wrapper on the other, with at most one transaction outstanding. It also bounds each transaction with a timeout so a missing memory response cannot hang the core.

---
 rtl/ysyx_24100005_mem_arbiter_pkg.sv | 25 ++
 rtl/ysyx_24100005_mem_arbiter_if.sv | 30 +++
 rtl/ysyx_24100005_mem_arbiter_grant.sv | 47 ++++
 rtl/ysyx_24100005_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_ysyx_24100005_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24100005_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100005_arb_pkg
// Brief    : Shared types and constants for the NPC data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_24100005_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    // Read data returned alongside a timeout error response.
    localparam logic [31:0] c_err_rdata = 32'h0;

endpackage
`default_nettype wire

// File: rtl/ysyx_24100005_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100005_mem_arbiter_if
// Brief    : Request/response bus shared by the IFU, LSU and memory sides.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_24100005_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wmask;
    logic              resp_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, addr, wen, wdata, wmask,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask,
        output req_ready, resp_valid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24100005_mem_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100005_arb_grant
// Brief    : Grant picker; round-robin with last_grant when ARB_RR_EN is
//            defined, otherwise fixed LSU-over-IFU priority.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100005_arb_grant
    import ysyx_24100005_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ifu_valid,
    input  logic       i_lsu_valid,
    input  logic       i_accept,
    output arb_owner_t o_grant
);

`ifdef ARB_RR_EN
    arb_owner_t r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= OWN_IFU;
        end else if (i_accept) begin
            r_last_grant <= o_grant;
        end
    end

    // On contention the requester not served last time wins.
    always_comb begin
        o_grant = OWN_IFU;
        if (i_ifu_valid && i_lsu_valid) begin
            o_grant = (r_last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (i_lsu_valid) begin
            o_grant = OWN_LSU;
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, i_accept, i_ifu_valid};

    assign o_grant = i_lsu_valid ? OWN_LSU : OWN_IFU;
`endif

endmodule
`default_nettype wire

// File: rtl/ysyx_24100005_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100005_mem_arbiter
// Brief    : IFU/LSU arbiter and single-outstanding sequencer for the NPC data
//            memory port, with transaction timeout. Macro: ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100005_mem_arbiter
    import ysyx_24100005_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_24100005_mem_arbiter_if.slave  ifu,
    ysyx_24100005_mem_arbiter_if.slave  lsu,
    ysyx_24100005_mem_arbiter_if.master mem,
    output logic                        bus_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Counter is 0 in the first ISSUE cycle, so the last allowed busy cycle
    // (accept + TIMEOUT_CYC - 1) sees TIMEOUT_CYC - 2.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 2);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    arb_owner_t        r_owner;
    arb_owner_t        w_grant;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wmask;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic w_any_req;
    logic w_accept;
    logic w_busy;
    logic w_timeout;
    logic w_mem_resp;
    logic w_unused_ifu;

    assign w_any_req  = ifu.req_valid | lsu.req_valid;
    assign w_accept   = (r_state == IDLE) & w_any_req;
    assign w_busy     = (r_state == ISSUE) | (r_state == WAIT);
    assign w_timeout  = w_busy & (r_cnt == c_cnt_last);
    assign w_mem_resp = (r_state == WAIT) & mem.resp_valid;

    // The IFU only reads; its write-side bus fields are never sampled.
    assign w_unused_ifu = &{1'b0, ifu.wen, ifu.wdata, ifu.wmask};

    ysyx_24100005_arb_grant u_grant (
        .clk         (clk),
        .rst         (rst),
        .i_ifu_valid (ifu.req_valid),
        .i_lsu_valid (lsu.req_valid),
        .i_accept    (w_accept),
        .o_grant     (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_next = ISSUE;
            ISSUE: begin
                if (w_timeout)          w_state_next = RESP;
                else if (mem.req_ready) w_state_next = WAIT;
            end
            // A response landing on the timeout cycle still counts as a response.
            WAIT:    if (mem.resp_valid || w_timeout) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_owner <= w_grant;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            if (w_grant == OWN_LSU) begin
                r_addr  <= lsu.addr;
                r_wen   <= lsu.wen;
                r_wdata <= lsu.wdata;
                r_wmask <= lsu.wmask;
            end else begin
                r_addr  <= ifu.addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wmask <= '0;
            end
        end else if (w_mem_resp) begin
            r_rdata <= r_wen ? '0 : mem.rdata;
        end else if (w_timeout) begin
            r_rdata <= DATA_W'(c_err_rdata);
            r_err   <= 1'b1;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        ifu.req_ready  = 1'b0;
        lsu.req_ready  = 1'b0;
        mem.req_valid  = 1'b0;
        ifu.resp_valid = 1'b0;
        lsu.resp_valid = 1'b0;
        bus_err        = 1'b0;
        case (r_state)
            IDLE: begin
                ifu.req_ready = ifu.req_valid & (w_grant == OWN_IFU);
                lsu.req_ready = lsu.req_valid & (w_grant == OWN_LSU);
            end
            ISSUE:   mem.req_valid = ~w_timeout;
            RESP: begin
                ifu.resp_valid = (r_owner == OWN_IFU);
                lsu.resp_valid = (r_owner == OWN_LSU);
                bus_err        = r_err;
            end
            default: ;
        endcase
    end

    assign ifu.rdata = ((r_state == RESP) && (r_owner == OWN_IFU)) ? r_rdata : '0;
    assign lsu.rdata = ((r_state == RESP) && (r_owner == OWN_LSU)) ? r_rdata : '0;
    assign mem.addr  = r_addr;
    assign mem.wen   = r_wen;
    assign mem.wdata = r_wdata;
    assign mem.wmask = r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24100005_mem_arbiter
// Brief    : Directed self-checking bench for the NPC memory arbiter
//            (TIMEOUT_CYC = 8; expectations follow ARB_RR_EN if defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100005_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic bus_err;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    ysyx_24100005_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_bus ();
    ysyx_24100005_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
    ysyx_24100005_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    ysyx_24100005_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ifu     (ifu_bus),
        .lsu     (lsu_bus),
        .mem     (mem_bus),
        .bus_err (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lsu_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [7:0] m);
        lsu_bus.req_valid = 1'b1;
        lsu_bus.addr      = a;
        lsu_bus.wen       = w;
        lsu_bus.wdata     = d;
        lsu_bus.wmask     = m;
    endtask

    // Entered in the first ISSUE cycle; returns in the RESP cycle.
    task automatic serve(input logic [31:0] rd);
        mem_bus.req_ready  = 1'b1;
        tick();
        mem_bus.req_ready  = 1'b0;
        mem_bus.resp_valid = 1'b1;
        mem_bus.rdata      = rd;
        tick();
        mem_bus.resp_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_lsu;
        rst = 1'b1;
        ifu_bus.req_valid = 1'b0; ifu_bus.addr = '0; ifu_bus.wen = 1'b0;
        ifu_bus.wdata = '0; ifu_bus.wmask = '0;
        lsu_bus.req_valid = 1'b0; lsu_bus.addr = '0; lsu_bus.wen = 1'b0;
        lsu_bus.wdata = '0; lsu_bus.wmask = '0;
        mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b0; mem_bus.rdata = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check("rst_memv",  mem_bus.req_valid, 0);
        check("rst_addr",  mem_bus.addr, 0);
        check("rst_resp",  {ifu_bus.resp_valid, lsu_bus.resp_valid, bus_err}, 0);

        // Contention after reset: LSU first, IFU at the next IDLE with wen/wmask forced 0.
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0000;
        ifu_bus.wen = 1'b1; ifu_bus.wmask = 8'hFF;
        lsu_req(32'h8000_0100, 1'b0, 32'h0, 8'h0);
        #1;
        check("a_lsu_rdy", lsu_bus.req_ready, 1);
        check("a_ifu_rdy", ifu_bus.req_ready, 0);
        tick();
        lsu_bus.req_valid = 1'b0;
        #1;
        check("a_addr",     mem_bus.addr, 32'h8000_0100);
        check("a_ifu_busy", ifu_bus.req_ready, 0);
        serve(32'h1111_1111);
        check("a_lsu_resp",  lsu_bus.resp_valid, 1);
        check("a_lsu_rdata", lsu_bus.rdata, 32'h1111_1111);
        check("a_ifu_rdy_resp", ifu_bus.req_ready, 0);
        tick();
        check("a_ifu_rdy2", ifu_bus.req_ready, 1);
        tick();
        ifu_bus.req_valid = 1'b0;
        #1;
        check("a_ifu_addr",  mem_bus.addr, 32'h8000_0000);
        check("a_ifu_wen",   mem_bus.wen, 0);
        check("a_ifu_wmask", mem_bus.wmask, 0);
        serve(32'h2222_2222);
        check("a_ifu_resp",  ifu_bus.resp_valid, 1);
        check("a_ifu_rdata", ifu_bus.rdata, 32'h2222_2222);
        check("a_lsu_quiet", lsu_bus.resp_valid, 0);
        tick();

        // Minimum-latency load then a store.
        lsu_req(32'h8000_0010, 1'b0, 32'h0, 8'h0);
        #1;
        check("b_rdy_c0", lsu_bus.req_ready, 1);
        tick();
        lsu_bus.req_valid = 1'b0;
        #1;
        check("b_memv_c1", mem_bus.req_valid, 1);
        check("b_addr_c1", mem_bus.addr, 32'h8000_0010);
        mem_bus.req_ready = 1'b1;
        tick();
        mem_bus.req_ready = 1'b0;
        #1;
        check("b_memv_c2", mem_bus.req_valid, 0);
        mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'h1234_5678;
        tick();
        mem_bus.resp_valid = 1'b0;
        #1;
        check("b_resp_c3",  lsu_bus.resp_valid, 1);
        check("b_rdata_c3", lsu_bus.rdata, 32'h1234_5678);
        check("b_err_c3",   bus_err, 0);
        tick();
        lsu_req(32'h8000_0020, 1'b1, 32'hAABB_CCDD, 8'h0F);
        #1;
        check("b_rdy_c4", lsu_bus.req_ready, 1);
        tick();
        lsu_bus.req_valid = 1'b0; lsu_bus.wdata = '0; lsu_bus.wmask = '0;
        #1;
        check("s_wen",    mem_bus.wen, 1);
        check("s_wdata1", mem_bus.wdata, 32'hAABB_CCDD);
        check("s_wmask1", mem_bus.wmask, 8'h0F);
        tick();
        check("s_memv2",  mem_bus.req_valid, 1);
        check("s_wdata2", mem_bus.wdata, 32'hAABB_CCDD);
        check("s_wmask2", mem_bus.wmask, 8'h0F);
        serve(32'hDEAD_BEEF);
        check("s_resp",  lsu_bus.resp_valid, 1);
        check("s_rdata", lsu_bus.rdata, 0);
        tick();

        // Both held valid for three transactions (last accept so far: LSU).
`ifdef ARB_RR_EN
        exp_lsu = 3'b010;
`else
        exp_lsu = 3'b111;
`endif
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0004;
        lsu_req(32'h8000_0008, 1'b0, 32'h0, 8'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("c_lsu_rdy%0d", i), lsu_bus.req_ready, {31'b0, exp_lsu[i]});
            check($sformatf("c_ifu_rdy%0d", i), ifu_bus.req_ready, {31'b0, ~exp_lsu[i]});
            tick();
            check($sformatf("c_addr%0d", i), mem_bus.addr,
                  exp_lsu[i] ? 32'h8000_0008 : 32'h8000_0004);
            serve(32'hC000_0000 + i);
            check($sformatf("c_resp%0d", i),
                  exp_lsu[i] ? lsu_bus.resp_valid : ifu_bus.resp_valid, 1);
            tick();
        end
        ifu_bus.req_valid = 1'b0;
        lsu_bus.req_valid = 1'b0;

        // Memory never answers: error response 8 cycles after accept.
        lsu_req(32'h8000_0200, 1'b0, 32'h0, 8'h0);
        #1;
        check("d_rdy", lsu_bus.req_ready, 1);
        tick();
        lsu_bus.req_valid = 1'b0;
        #1;
        check("d_memv", mem_bus.req_valid, 1);
        for (int c = 1; c < 8; c++) begin
            check($sformatf("d_quiet%0d", c), {lsu_bus.resp_valid, bus_err}, 0);
            tick();
            #1;
        end
        check("d_resp",  lsu_bus.resp_valid, 1);
        check("d_rdata", lsu_bus.rdata, 0);
        check("d_err",   bus_err, 1);
        check("d_memv8", mem_bus.req_valid, 0);
        tick();
        check("d_err_end", {lsu_bus.resp_valid, bus_err}, 0);
        lsu_bus.req_valid = 1'b1;
        #1;
        check("d_idle", lsu_bus.req_ready, 1);
        lsu_bus.req_valid = 1'b0;
        tick();

        // Response on the timeout cycle wins over the error.
        lsu_req(32'h8000_0300, 1'b0, 32'h0, 8'h0);
        tick();
        lsu_bus.req_valid = 1'b0;
        mem_bus.req_ready = 1'b1;
        tick();
        mem_bus.req_ready = 1'b0;
        repeat (5) tick();
        mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'h5555_AAAA;
        tick();
        mem_bus.resp_valid = 1'b0;
        #1;
        check("e_resp",  lsu_bus.resp_valid, 1);
        check("e_rdata", lsu_bus.rdata, 32'h5555_AAAA);
        check("e_err",   bus_err, 0);
        tick();

        // Reset while in WAIT; a late response must be ignored.
        lsu_req(32'h8000_0400, 1'b0, 32'h0, 8'h0);
        tick();
        lsu_bus.req_valid = 1'b0;
        mem_bus.req_ready = 1'b1;
        tick();
        mem_bus.req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("f_memv", mem_bus.req_valid, 0);
        check("f_addr", mem_bus.addr, 0);
        tick();
        rst = 1'b0;
        mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'h7777_7777;
        tick();
        mem_bus.resp_valid = 1'b0;
        #1;
        check("f_resp1", {ifu_bus.resp_valid, lsu_bus.resp_valid, bus_err, mem_bus.req_valid}, 0);
        tick();
        check("f_resp2", {ifu_bus.resp_valid, lsu_bus.resp_valid, bus_err}, 0);
        check("f_rdata", lsu_bus.rdata | ifu_bus.rdata, 0);

        // Stray response in IDLE.
        mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'h9999_9999;
        tick();
        mem_bus.resp_valid = 1'b0;
        #1;
        check("g_resp", {ifu_bus.resp_valid, lsu_bus.resp_valid, mem_bus.req_valid}, 0);
        lsu_bus.req_valid = 1'b1;
        #1;
        check("g_idle", lsu_bus.req_ready, 1);
        lsu_bus.req_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
